// File: rtl/cluster_pkg.sv
// Shared definitions for the cluster frame checker: FSM state codes and a
// reference two's-complement checksum helper for frame encoders.
package cluster_pkg;

   typedef logic [1:0] state_t;

   localparam state_t COLLECT = 2'd0;
   localparam state_t DRAIN   = 2'd1;
   localparam state_t RESULT  = 2'd2;

   localparam int CSUM_MAX_W = 32;
   localparam int CSUM_MAX_N = 16;

   // Checksum of the first n words (each w bits wide, packed at a 32-bit stride).
   function automatic logic [CSUM_MAX_W-1:0] frame_csum(
      input logic [CSUM_MAX_N*CSUM_MAX_W-1:0] words,
      input int                               n,
      input int                               w
   );
      logic [CSUM_MAX_W-1:0] sum;
      logic [CSUM_MAX_W-1:0] mask;
      sum = '0;
      for (int i = 0; i < CSUM_MAX_N; i++) begin
         if (i < n) begin
            sum = sum + words[i*CSUM_MAX_W +: CSUM_MAX_W];
         end else begin
            sum = sum;
         end
      end
      mask = (w >= CSUM_MAX_W) ? {CSUM_MAX_W{1'b1}} : ((32'd1 << w) - 32'd1);
      return (~sum + 32'd1) & mask;
   endfunction

endpackage

// File: rtl/cluster_csum_acc.sv
// Running modulo-2^DATA_W accumulator; flags when sum plus the current word wraps to zero.
module cluster_csum_acc #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              add_i,
   input  logic [DATA_W-1:0] word_i,
   output logic              zero_o
);

   logic [DATA_W-1:0] sum_q;
   logic [DATA_W-1:0] sum_d;
   logic [DATA_W-1:0] total_s;

   // Next sum: clear has priority over add; carries fall off the top.
   always_comb begin
      total_s = sum_q + word_i;
      if (clr_i) begin
         sum_d = '0;
      end else if (add_i) begin
         sum_d = total_s;
      end else begin
         sum_d = sum_q;
      end
   end

   // Sum register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign zero_o = (total_s == '0);

endmodule

// File: rtl/cluster_frame_checker.sv
// Collects NUM_CLUSTERS words plus a checksum word, verifies the frame and
// presents it in parallel; keeps saturating good/bad frame counters.
module cluster_frame_checker
   import cluster_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int NUM_CLUSTERS = 4,
   parameter int DROP_BAD     = 0,
   parameter int CNT_W        = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [NUM_CLUSTERS*DATA_W-1:0] out_data,
   output logic                           out_ok,
   output logic                           out_len_err,
   output logic [CNT_W-1:0]               good_cnt,
   output logic [CNT_W-1:0]               bad_cnt
);

   localparam int IDX_W = $clog2(NUM_CLUSTERS + 1);
   localparam int BUF_W = NUM_CLUSTERS * DATA_W;
   localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NUM_CLUSTERS);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [BUF_W-1:0]   out_data_q, out_data_d;
   logic               out_ok_q, out_ok_d;
   logic               out_len_err_q, out_len_err_d;
   logic [CNT_W-1:0]   good_q, good_d;
   logic [CNT_W-1:0]   bad_q, bad_d;

   logic xfer_s;
   logic acc_add_s;
   logic acc_zero_s;
   logic frame_end_s;
   logic frame_good_s;
   logic frame_len_err_s;

   assign xfer_s = in_valid && in_ready_q;

   cluster_csum_acc #(
      .DATA_W (DATA_W)
   ) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (frame_end_s),
      .add_i  (acc_add_s),
      .word_i (in_data),
      .zero_o (acc_zero_s)
   );

   // Frame sequencing, word capture, result formation and counters
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      buf_d           = buf_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_ok_d        = out_ok_q;
      out_len_err_d   = out_len_err_q;
      good_d          = good_q;
      bad_d           = bad_q;
      acc_add_s       = 1'b0;
      frame_end_s     = 1'b0;
      frame_good_s    = 1'b0;
      frame_len_err_s = 1'b0;

      case (state_q)
         COLLECT: begin
            if (xfer_s && (idx_q != CSUM_IDX)) begin
               if (in_last) begin
                  frame_end_s     = 1'b1;
                  frame_len_err_s = 1'b1;
               end else begin
                  acc_add_s = 1'b1;
                  idx_d     = idx_q + IDX_W'(1);
                  for (int k = 0; k < NUM_CLUSTERS; k++) begin
                     buf_d[k*DATA_W +: DATA_W] = (idx_q == IDX_W'(k)) ? in_data
                                                                      : buf_q[k*DATA_W +: DATA_W];
                  end
               end
            end else if (xfer_s) begin
               if (in_last) begin
                  frame_end_s  = 1'b1;
                  frame_good_s = acc_zero_s;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               state_d = COLLECT;
            end
         end
         DRAIN: begin
            if (xfer_s && in_last) begin
               frame_end_s     = 1'b1;
               frame_len_err_s = 1'b1;
            end else begin
               state_d = DRAIN;
            end
         end
         RESULT: begin
            if (out_ready) begin
               state_d       = COLLECT;
               out_valid_d   = 1'b0;
               out_data_d    = '0;
               out_ok_d      = 1'b0;
               out_len_err_d = 1'b0;
            end else begin
               state_d = RESULT;
            end
         end
         default: begin
            state_d = COLLECT;
         end
      endcase

      // The buffer has already been copied out, so the next frame starts clean.
      if (frame_end_s) begin
         idx_d = '0;
         buf_d = '0;
         if (frame_good_s || (DROP_BAD == 0)) begin
            state_d       = RESULT;
            out_valid_d   = 1'b1;
            out_ok_d      = frame_good_s;
            out_len_err_d = frame_len_err_s;
            out_data_d    = frame_good_s ? buf_q : '0;
         end else begin
            state_d = COLLECT;
         end
         if (frame_good_s) begin
            good_d = (good_q != CNT_MAX) ? good_q + CNT_W'(1) : good_q;
         end else begin
            bad_d  = (bad_q != CNT_MAX) ? bad_q + CNT_W'(1) : bad_q;
         end
      end else begin
         idx_d = idx_d;
      end

      in_ready_d = (state_d != RESULT);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= COLLECT;
         idx_q         <= '0;
         buf_q         <= '0;
         in_ready_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_ok_q      <= 1'b0;
         out_len_err_q <= 1'b0;
         good_q        <= '0;
         bad_q         <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         buf_q         <= buf_d;
         in_ready_q    <= in_ready_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_ok_q      <= out_ok_d;
         out_len_err_q <= out_len_err_d;
         good_q        <= good_d;
         bad_q         <= bad_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_ok      = out_ok_q;
   assign out_len_err = out_len_err_q;
   assign good_cnt    = good_q;
   assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_cluster_frame_checker.sv
// Directed and random frames against two checker instances (emit-bad with wide
// counters, drop-bad with 2-bit counters), judged by a frame-level model.
module tb_cluster_frame_checker;
   import cluster_pkg::*;

   localparam int DW  = 8;
   localparam int N   = 4;
   localparam int CW  = 16;
   localparam int DCW = 2;
   localparam int DMAX = 3;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_last   = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data   = '0;

   logic            in_ready, out_valid, out_ok, out_len_err;
   logic [N*DW-1:0] out_data;
   logic [CW-1:0]   good_cnt, bad_cnt;

   logic            d_in_valid, d_in_ready, d_out_valid, d_out_ok, d_out_len_err;
   logic [N*DW-1:0] d_out_data;
   logic [DCW-1:0]  d_good_cnt, d_bad_cnt;

   int checks   = 0;
   int failures = 0;

   int cur_q[$];
   int fw[$];
   int exp_good = 0, exp_bad = 0, exp_dgood = 0, exp_dbad = 0;
   logic [N*DW-1:0] exp_data;
   logic            exp_ok, exp_len;

   always #5 clk = ~clk;

   // The drop-bad instance only sees transfers the main instance also accepts.
   assign d_in_valid = in_valid & in_ready;

   cluster_frame_checker #(.DATA_W(DW), .NUM_CLUSTERS(N), .DROP_BAD(0), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ok(out_ok), .out_len_err(out_len_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt));

   cluster_frame_checker #(.DATA_W(DW), .NUM_CLUSTERS(N), .DROP_BAD(1), .CNT_W(DCW)) dut_drop (
      .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(in_data),
      .in_last(in_last), .out_valid(d_out_valid), .out_ready(out_ready), .out_data(d_out_data),
      .out_ok(d_out_ok), .out_len_err(d_out_len_err), .good_cnt(d_good_cnt), .bad_cnt(d_bad_cnt));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int d, input logic l);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = DW'(d);
      in_last  = l;
      while (in_ready !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      chk("push_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      cur_q.push_back(d & 255);
   endtask

   task automatic send_frame();
      for (int i = 0; i < fw.size(); i++) begin
         if (i > N) chk("drain_ready", {63'd0, in_ready}, 64'd1);
         push(fw[i], (i == fw.size() - 1));
      end
   endtask

   task automatic check_result(input int hold, input logic held_next, input int nw);
      int n;
      int sum;
      n   = cur_q.size();
      sum = 0;
      foreach (cur_q[i]) sum += cur_q[i];
      exp_ok   = (n == N + 1) && (sum % 256 == 0);
      exp_len  = (n != N + 1);
      exp_data = '0;
      if (exp_ok) begin
         for (int k = 0; k < N; k++) exp_data[k*DW +: DW] = DW'(cur_q[k]);
         exp_good++;
         if (exp_dgood < DMAX) exp_dgood++;
      end else begin
         exp_bad++;
         if (exp_dbad < DMAX) exp_dbad++;
      end
      cur_q.delete();

      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_ok", {63'd0, out_ok}, {63'd0, exp_ok});
      chk("out_len_err", {63'd0, out_len_err}, {63'd0, exp_len});
      chk("out_data", {32'd0, out_data}, {32'd0, exp_data});
      chk("in_ready_result", {63'd0, in_ready}, 64'd0);
      chk("drop_valid", {63'd0, d_out_valid}, {63'd0, exp_ok});
      if (exp_ok) begin
         chk("drop_data", {32'd0, d_out_data}, {32'd0, exp_data});
         chk("drop_ok", {63'd0, d_out_ok}, 64'd1);
         chk("drop_len", {63'd0, d_out_len_err}, 64'd0);
      end
      if (held_next) begin
         in_valid = 1'b1;
         in_data  = DW'(nw);
         in_last  = 1'b0;
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_data", {32'd0, out_data}, {32'd0, exp_data});
         chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("after_valid", {63'd0, out_valid}, 64'd0);
      chk("after_drop_valid", {63'd0, d_out_valid}, 64'd0);
      chk("after_in_ready", {63'd0, in_ready}, 64'd1);
      chk("good_cnt", {48'd0, good_cnt}, 64'(exp_good));
      chk("bad_cnt", {48'd0, bad_cnt}, 64'(exp_bad));
      chk("drop_good_cnt", {62'd0, d_good_cnt}, 64'(exp_dgood));
      chk("drop_bad_cnt", {62'd0, d_bad_cnt}, 64'(exp_dbad));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      cur_q.delete();
      exp_good  = 0;
      exp_bad   = 0;
      exp_dgood = 0;
      exp_dbad  = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_out_ok", {63'd0, out_ok}, 64'd0);
      chk("rst_len_err", {63'd0, out_len_err}, 64'd0);
      chk("rst_good", {48'd0, good_cnt}, 64'd0);
      chk("rst_bad", {48'd0, bad_cnt}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_drop_bad", {62'd0, d_bad_cnt}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready_up", {63'd0, in_ready}, 64'd1);
   endtask

   task automatic make_good_frame();
      logic [CSUM_MAX_N*CSUM_MAX_W-1:0] pk;
      logic [CSUM_MAX_W-1:0]            c;
      pk = '0;
      fw.delete();
      for (int k = 0; k < N; k++) begin
         fw.push_back(int'($urandom_range(0, 255)));
         pk[k*CSUM_MAX_W +: CSUM_MAX_W] = fw[k];
      end
      c = frame_csum(pk, N, DW);
      fw.push_back(int'(c));
   endtask

   initial begin
      int kind;
      int len;

      do_reset();

      // Reference good frame, then the same data with a wrong checksum.
      fw = '{72, 69, 76, 80, 215};
      send_frame();
      check_result(0, 1'b0, 0);
      fw = '{72, 69, 76, 80, 214};
      send_frame();
      check_result(0, 1'b0, 0);

      // Short frame, then a good frame.
      fw = '{1, 2, 253};
      send_frame();
      check_result(1, 1'b0, 0);
      fw = '{16, 32, 48, 64, 96};
      send_frame();
      check_result(0, 1'b0, 0);

      // Long frame: fifth word without last, two more, then last.
      fw = '{1, 2, 3, 4, 246, 7, 8, 9};
      send_frame();
      check_result(0, 1'b0, 0);

      // Backpressure with a next-frame word held on the input.
      fw = '{17, 34, 51, 68, 86};
      send_frame();
      check_result(5, 1'b1, 17);
      fw = '{34, 51, 68, 86};
      for (int i = 0; i < fw.size(); i++) push(fw[i], (i == fw.size() - 1));
      check_result(0, 1'b0, 0);

      // Reset in the middle of a frame.
      push(5, 1'b0);
      push(6, 1'b0);
      do_reset();
      fw = '{72, 69, 76, 80, 215};
      send_frame();
      check_result(0, 1'b0, 0);

      // Random frames of every kind.
      for (int f = 0; f < 40; f++) begin
         kind = int'($urandom_range(0, 3));
         if (kind == 0) begin
            make_good_frame();
         end else if (kind == 1) begin
            make_good_frame();
            fw[N] = (fw[N] + int'($urandom_range(1, 255))) & 255;
         end else begin
            len = (kind == 2) ? int'($urandom_range(1, N)) : int'($urandom_range(N + 2, N + 4));
            fw.delete();
            for (int k = 0; k < len; k++) fw.push_back(int'($urandom_range(0, 255)));
         end
         send_frame();
         check_result(int'($urandom_range(0, 3)), 1'b0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cluster_frame_checker.md
Name: cluster_frame_checker

Overview:
Streaming successor to the four-cluster message checker. Accepts frames of NUM_CLUSTERS data words plus one two's-complement checksum word over a valid/ready input stream. It verifies the checksum and presents the whole frame in parallel on a valid/ready output, or zeros with an error flag when the check fails. It sits between the byte-level receiver and the message consumer, and keeps saturating good/bad frame counters for debug.

Parameters:
DATA_W, 8, width of one cluster word and of the checksum word
NUM_CLUSTERS, 4, data words per frame (>=1); the checksum word follows them
DROP_BAD, 0, 1 = bad frames produce no output beat (counter only); 0 = bad frames emit a zero beat with out_ok=0
CNT_W, 16, width of the good/bad frame counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept an input word
in_data  in  DATA_W  cluster word or checksum word
in_last  in  1  marks the checksum word (last word of the frame)
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts the result
out_data  out  NUM_CLUSTERS*DATA_W  cluster k in bits [k*DATA_W +: DATA_W]; all zero when out_ok=0
out_ok  out  1  1 = checksum matched and length correct
out_len_err  out  1  qualifies out_ok=0: frame length was wrong
good_cnt  out  CNT_W  frames passed, saturating
bad_cnt  out  CNT_W  frames failed (checksum or length), saturating

Behaviour:
- Reset (async assert, sync deassert as seen by logic): state COLLECT, word index 0, running sum 0, buffer 0, out_valid 0, out_data 0, out_ok 0, out_len_err 0, both counters 0. in_ready=1 one cycle after rst_n rises. A reset mid-frame or mid-output discards everything.
- Transfer occurs when valid&&ready on the same edge.
- Sum is modulo 2^DATA_W; carries are discarded. A frame is good when (sum of data words + checksum word) mod 2^DATA_W == 0, i.e. checksum == (~sum + 1).
- States:
  - COLLECT: in_ready=1. On a transfer with index<NUM_CLUSTERS and in_last=0, store the word at index, add it to sum, and index++. On a transfer with index<NUM_CLUSTERS and in_last=1 (short frame), the frame is bad with len_err; go to RESULT. On a transfer with index==NUM_CLUSTERS, the word is the checksum: if in_last=1, evaluate and go to RESULT; if in_last=0 (long frame), mark bad with len_err and go to DRAIN.
  - DRAIN: in_ready=1. Discard words until a transfer with in_last=1, then go to RESULT (bad, len_err).
  - RESULT: in_ready=0. out_valid=1, and out_data/out_ok/out_len_err are held stable until out_ready. On the handshake, clear index, sum and buffer and return to COLLECT. With DROP_BAD=1 a bad frame skips RESULT and returns to COLLECT directly, so out_valid is never raised.
- Latency: out_valid rises on the cycle after the checksum (in_last) transfer. With out_ready tied high, one input bubble occurs per frame, so throughput is NUM_CLUSTERS+1 words per NUM_CLUSTERS+2 cycles.
- Counters: incremented once per frame at frame end (the in_last transfer). They hold at 2^CNT_W-1.
- out_data is zero whenever out_ok=0, whether the failure was a checksum mismatch or a length error.
- in_valid while in_ready=0 is ignored; the source must hold the word. out_valid never drops without out_ready.

Decomposition:
- Shared package cluster_pkg: state enum {COLLECT, DRAIN, RESULT}, plus a function computing the two's-complement checksum of a word array (reused by the bench and the encoder).
- One natural sub-module: cluster_csum_acc, the running modulo-2^DATA_W accumulator with clear, add-enable and is_zero(sum+word) output.

Test Plan:
- Good frame, defaults: 0x48,0x45,0x4C,0x50, then 0xD7 with in_last -> next cycle out_valid=1, out_ok=1, out_data=0x504C4548, good_cnt=1.
- Bad checksum: same data, then 0xD6 last -> out_ok=0, out_len_err=0, out_data=0, bad_cnt=1. With DROP_BAD=1: out_valid stays 0 and bad_cnt=1.
- Short frame: 0x01,0x02, then 0xFD last -> out_ok=0, out_len_err=1, bad_cnt=1. A following good frame passes.
- Long frame: five words, the fifth with in_last=0, then two words and one with in_last=1 -> single bad result with out_len_err=1, and in_ready=1 throughout DRAIN.
- Backpressure: good frame with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0, a next-frame word held on in_data is not taken until the handshake.
- Reset mid-frame: rst_n low after 2 words, then a full good frame -> only one result (ok) is emitted, and the counters show good=1, bad=0.
